// File: rtl/signed_logic_pkg.sv
// Shared opcode encodings and default operand width for the signed_logic block.
package signed_logic_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

endpackage

// File: rtl/signed_logic_core.sv
// Combinational bitwise operation decode; anything that is not AND/OR/XOR selects NOT.
module signed_logic_core
  import signed_logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [1:0]       sel,
  output logic signed [WIDTH-1:0] res
);

  always_comb begin
    res = ~a;
    case (sel)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = ~a;
    endcase
  end

endmodule

// File: rtl/signed_logic.sv
// Registered bitwise logic unit: one-cycle latency, result plus zero/negative flags.
module signed_logic
  import signed_logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [1:0]       sel,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    zero,
  output logic                    neg
);

  logic signed [WIDTH-1:0] res_p0_d;
  logic signed [WIDTH-1:0] res_p1_q;
  logic                    vld_p1_q;
  logic                    zero_p1_q;
  logic                    neg_p1_q;

  function automatic logic is_zero(input logic signed [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  signed_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .sel(sel),
    .res(res_p0_d)
  );

  // p0 -> p1: flags are registered with the result so they always describe out
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      zero_p1_q <= 1'b1;
      neg_p1_q  <= 1'b0;
    end else begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        res_p1_q  <= res_p0_d;
        zero_p1_q <= is_zero(res_p0_d);
        neg_p1_q  <= res_p0_d[WIDTH-1];
      end
    end
  end

  assign out       = res_p1_q;
  assign out_valid = vld_p1_q;
  assign zero      = zero_p1_q;
  assign neg       = neg_p1_q;

endmodule

// File: tb/tb_signed_logic.sv
// Bench for signed_logic: directed vector table followed by randomized traffic against a bit-level model.
module tb_signed_logic;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    sel;
  logic [W-1:0]  out;
  logic          out_valid;
  logic          zero;
  logic          neg;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  signed_logic #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .out      (out),
    .out_valid(out_valid),
    .zero     (zero),
    .neg      (neg)
  );

  typedef struct {
    logic         rst;
    logic         vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic [W-1:0] e_out;
    logic         e_vld;
    logic         e_zero;
    logic         e_neg;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic r, logic v, logic [W-1:0] xa, logic [W-1:0] xb,
                              logic [1:0] s, logic [W-1:0] eo, logic ev, logic ez, logic en);
    vec_t t;
    t.rst = r; t.vld = v; t.a = xa; t.b = xb; t.sel = s;
    t.e_out = eo; t.e_vld = ev; t.e_zero = ez; t.e_neg = en;
    return t;
  endfunction

  // Reference: each result bit from a truth-table rule on the operand bits.
  function automatic logic [W-1:0] model_op(logic [W-1:0] xa, logic [W-1:0] xb, logic [1:0] s);
    logic [W-1:0] r;
    int x, y;
    for (int i = 0; i < W; i++) begin
      x = int'(xa[i]);
      y = int'(xb[i]);
      case (s)
        2'd0:    r[i] = (x * y) != 0;
        2'd1:    r[i] = (x + y) > 0;
        2'd2:    r[i] = ((x + y) % 2) == 1;
        default: r[i] = (1 - x) == 1;
      endcase
    end
    return r;
  endfunction

  task automatic check(string name, logic [W-1:0] ao, logic av, logic az, logic an,
                       logic [W-1:0] eo, logic ev, logic ez, logic en);
    tests_run++;
    if (ao !== eo || av !== ev || az !== ez || an !== en) begin
      tests_failed++;
      $display("FAIL %s: got out=%h vld=%b zero=%b neg=%b, expected out=%h vld=%b zero=%b neg=%b",
               name, ao, av, az, an, eo, ev, ez, en);
    end
  endtask

  task automatic drive(logic r, logic v, logic [W-1:0] xa, logic [W-1:0] xb, logic [1:0] s);
    rst = r; in_valid = v; a = xa; b = xb; sel = s;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] m_out;
  logic         m_vld;
  logic         r_rst, r_vld;
  logic [W-1:0] r_a, r_b;
  logic [1:0]   r_sel;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = 2'b00;

    tbl[0]  = mk(1, 0, 32'h0, 32'h0, 2'b00, 32'h0, 0, 1, 0);
    tbl[1]  = mk(0, 1, 32'hFFFF0000, 32'h00FF00FF, 2'b00, 32'h00FF0000, 1, 0, 0);
    tbl[2]  = mk(0, 1, 32'hFFFF0000, 32'h00FF00FF, 2'b01, 32'hFFFF00FF, 1, 0, 1);
    tbl[3]  = mk(0, 1, 32'hFFFF0000, 32'h00FF00FF, 2'b10, 32'hFF0000FF, 1, 0, 1);
    tbl[4]  = mk(0, 1, 32'hFFFF0000, 32'h00FF00FF, 2'b11, 32'h0000FFFF, 1, 0, 0);
    tbl[5]  = mk(0, 1, 32'h0F0F0F0F, 32'hF0F0F0F0, 2'b00, 32'h0, 1, 1, 0);
    tbl[6]  = mk(0, 1, 32'(-57434535), 32'(832402423), 2'b11, 32'(57434534), 1, 0, 0);
    tbl[7]  = mk(0, 0, 32'hDEADBEEF, 32'h12345678, 2'b01, 32'(57434534), 0, 0, 0);
    tbl[8]  = mk(0, 0, 32'h0, 32'h0, 2'b11, 32'(57434534), 0, 0, 0);
    tbl[9]  = mk(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'(57434534), 0, 0, 0);
    tbl[10] = mk(1, 1, 32'hFFFFFFFF, 32'h1, 2'b01, 32'h0, 0, 1, 0);
    tbl[11] = mk(0, 1, 32'h80000000, 32'h0, 2'b01, 32'h80000000, 1, 0, 1);
    tbl[12] = mk(0, 0, 32'h0, 32'h0, 2'b00, 32'h80000000, 0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].sel);
      check($sformatf("vec%0d", i), out, out_valid, zero, neg,
            tbl[i].e_out, tbl[i].e_vld, tbl[i].e_zero, tbl[i].e_neg);
    end

    // Reset held across valid traffic, then first operation on first non-reset edge
    drive(1, 1, 32'h1234, 32'h00FF, 2'b10);
    drive(1, 1, 32'h5555, 32'hAAAA, 2'b01);
    check("rst_hold", out, out_valid, zero, neg, 32'h0, 0, 1, 0);
    drive(0, 1, 32'h0000FFFF, 32'h0F0F0F0F, 2'b10);
    check("post_rst", out, out_valid, zero, neg, 32'h0F0FF0F0, 1, 0, 0);

    // Randomized traffic with sporadic reset and idle cycles
    m_out = 32'h0F0FF0F0;
    m_vld = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 19) == 0);
      r_vld = ($urandom_range(0, 3) != 0);
      r_a   = $urandom;
      r_b   = $urandom;
      r_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) r_a = r_b;
      drive(r_rst, r_vld, r_a, r_b, r_sel);
      if (r_rst) begin
        m_out = '0;
        m_vld = 1'b0;
      end else if (r_vld) begin
        m_out = model_op(r_a, r_b, r_sel);
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      check($sformatf("rand%0d", n), out, out_valid, zero, neg,
            m_out, m_vld, (m_out == 0), m_out[W-1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
